// File: rtl/irq_controller.sv
// irq_controller: synchronised, maskable, lowest-index-first interrupt front-end for cp0
module irq_controller #(
  parameter int N_SRC       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_in,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic [31:0]      cfg_rdata,
  output logic             ir_out,
  input  logic             eret,
  output logic [ID_W-1:0]  irq_id,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, DISPATCH, WAIT} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0][N_SRC-1:0] sync;
  logic [N_SRC-1:0] s, s_d, mask, mode, pend, pend_nxt, req, clr;
  logic [ID_W-1:0] win;
  logic [31:0] rd_mux;
  logic unused_bits;
  assign unused_bits = ^cfg_wdata;
  assign s = sync[SYNC_STAGES-1];
  assign req = pend & mask;
  always_comb begin
    win = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (req[i]) win = ID_W'(i);
  end
  // Edge bits clear on W1C or at dispatch of the winner; a new edge in the same cycle wins.
  always_comb begin
    clr = (cfg_we && cfg_addr == 2'd2) ? cfg_wdata[N_SRC-1:0] : '0;
    if (state == DISPATCH) clr[irq_id] = 1'b1;
    pend_nxt = (mode & ((s & ~s_d) | (pend & ~clr))) | (~mode & s);
  end
  always_comb begin
    rd_mux = 32'(irq_id);
    rd_mux[31] = busy;
    rd_mux = cfg_addr == 2'd0 ? 32'(mask) :
             cfg_addr == 2'd1 ? 32'(mode) :
             cfg_addr == 2'd2 ? 32'(pend) : rd_mux;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync      <= '0;
      s_d       <= '0;
      mask      <= '0;
      mode      <= '0;
      pend      <= '0;
      cfg_rdata <= '0;
      ir_out    <= 1'b0;
      irq_id    <= '0;
      busy      <= 1'b0;
      state     <= IDLE;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], src_in};
      s_d       <= s;
      pend      <= pend_nxt;
      cfg_rdata <= rd_mux;
      if (cfg_we && cfg_addr == 2'd0) mask <= cfg_wdata[N_SRC-1:0];
      if (cfg_we && cfg_addr == 2'd1) mode <= cfg_wdata[N_SRC-1:0];
      case (state)
        IDLE: if (req != '0) begin
          state  <= DISPATCH;
          irq_id <= win;
          busy   <= 1'b1;
          ir_out <= 1'b1;
        end
        DISPATCH: begin
          state  <= WAIT;
          ir_out <= 1'b0;
        end
        WAIT: if (eret) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed checks of dispatch latency, priority, masking, W1C and reset
module tb_irq_controller;
  logic clk = 0, rst = 1, cfg_we = 0, eret = 0;
  logic [7:0] src_in = '0;
  logic [1:0] cfg_addr = '0;
  logic [31:0] cfg_wdata = '0, cfg_rdata;
  logic ir_out, busy;
  logic [2:0] irq_id;
  int vectors = 0, errs = 0;

  irq_controller dut (.clk(clk), .rst(rst), .src_in(src_in), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .ir_out(ir_out), .eret(eret), .irq_id(irq_id), .busy(busy));

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 0;
  endtask

  task automatic do_eret();
    eret = 1;
    tick();
    eret = 0;
  endtask

  initial begin
    tick(2);
    chk("rst ir_out", 32'(ir_out), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst irq_id", 32'(irq_id), 0);
    chk("rst rdata", cfg_rdata, 0);
    rst = 0;
    // 1: level source, 4-cycle latency, single-cycle pulse
    cfg_write(0, 32'hFF);
    src_in[3] = 1;
    tick(3);
    chk("t1 no early pulse", 32'(ir_out), 0);
    tick();
    chk("t1 pulse", 32'(ir_out), 1);
    chk("t1 id", 32'(irq_id), 3);
    chk("t1 busy", 32'(busy), 1);
    tick();
    chk("t1 pulse ends", 32'(ir_out), 0);
    chk("t1 still busy", 32'(busy), 1);
    src_in[3] = 0;
    tick(4);
    do_eret();
    chk("t1 eret busy", 32'(busy), 0);
    tick(2);
    chk("t1 no redispatch", 32'(ir_out), 0);
    // 2: simultaneous edges, lowest index first, idle gap before second
    cfg_write(1, 32'hFF);
    src_in[5] = 1; src_in[2] = 1;
    tick(4);
    chk("t2 first pulse", 32'(ir_out), 1);
    chk("t2 first id", 32'(irq_id), 2);
    src_in[5] = 0; src_in[2] = 0;
    tick(3);
    chk("t2 wait no pulse", 32'(ir_out), 0);
    chk("t2 wait id", 32'(irq_id), 2);
    do_eret();
    chk("t2 idle busy", 32'(busy), 0);
    chk("t2 idle gap", 32'(ir_out), 0);
    chk("t2 id kept", 32'(irq_id), 2);
    tick();
    chk("t2 second pulse", 32'(ir_out), 1);
    chk("t2 second id", 32'(irq_id), 5);
    tick();
    do_eret();
    cfg_addr = 2;
    tick();
    chk("t2 pend cleared", cfg_rdata, 0);
    // 3: masked edge pend retained until unmasked
    cfg_write(0, 32'h00);
    src_in[0] = 1;
    tick();
    src_in[0] = 0;
    cfg_addr = 2;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3 masked no pulse", 32'(ir_out), 0);
    end
    chk("t3 pend held", cfg_rdata, 32'h01);
    cfg_write(0, 32'h01);
    tick();
    chk("t3 unmask pulse", 32'(ir_out), 1);
    chk("t3 unmask id", 32'(irq_id), 0);
    tick();
    do_eret();
    // 4: set beats W1C clear in the same cycle; plain W1C clears
    cfg_write(0, 32'h00);
    src_in[1] = 1;
    tick();
    src_in[1] = 0;
    tick(3);
    cfg_addr = 2;
    tick();
    chk("t4 pend set", cfg_rdata, 32'h02);
    src_in[1] = 1;
    tick(2);
    cfg_write(2, 32'h02);
    src_in[1] = 0;
    tick();
    chk("t4 set wins", cfg_rdata, 32'h02);
    cfg_write(2, 32'h02);
    tick();
    chk("t4 w1c clears", cfg_rdata, 0);
    // 5: reset mid-service
    cfg_write(0, 32'hFF);
    src_in[4] = 1;
    tick(4);
    chk("t5 pulse id", 32'(irq_id), 4);
    src_in[4] = 0; src_in[6] = 1;
    tick(3);
    chk("t5 busy", 32'(busy), 1);
    src_in[6] = 0;
    rst = 1;
    tick();
    rst = 0;
    chk("t5 busy cleared", 32'(busy), 0);
    chk("t5 id cleared", 32'(irq_id), 0);
    chk("t5 no pulse", 32'(ir_out), 0);
    cfg_addr = 0;
    tick();
    chk("t5 mask cleared", cfg_rdata, 0);
    cfg_addr = 2;
    tick();
    chk("t5 pend cleared", cfg_rdata, 0);
    tick(3);
    chk("t5 still quiet", 32'(ir_out), 0);
    // 6: eret in IDLE ignored; STATUS readback
    cfg_write(0, 32'hFF);
    do_eret();
    chk("t6 idle eret busy", 32'(busy), 0);
    chk("t6 idle eret id", 32'(irq_id), 0);
    chk("t6 idle eret pulse", 32'(ir_out), 0);
    src_in[6] = 1;
    tick(4);
    chk("t6 pulse", 32'(ir_out), 1);
    chk("t6 id", 32'(irq_id), 6);
    cfg_addr = 3;
    tick();
    chk("t6 status", cfg_rdata, 32'h8000_0006);
    src_in[6] = 0;
    tick(4);
    do_eret();
    chk("t6 eret busy", 32'(busy), 0);
    tick();
    chk("t6 status idle", cfg_rdata, 32'h0000_0006);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
